conv_encoder: RTL and testbench
===============================

CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 i_constr_len  input  2  constraint length K: 2'b00=3, 2'b01=5, 2'b10=7, 2'b11=9.
REQ-005 i_gen_poly0  input  9  generator 0; bit j taps input delayed j steps; bits j>=K ignored.
REQ-006 i_gen_poly1  input  9  generator 1; same tap rule as i_gen_poly0.
REQ-007 i_start  input  1  single-cycle load request.
REQ-008 i_encoder_data  input  128  message block; bit 0 is encoded first.
REQ-009 i_code_ready  input  1  downstream accepts the current symbol.
REQ-010 o_code  output  2  code symbol {g0, g1}.
REQ-011 o_code_valid  output  1  o_code holds a valid symbol.
REQ-012 o_busy  output  1  block is encoding; i_start is ignored.
REQ-013 o_encoder_done  output  1  one-cycle pulse after the final symbol handshake.

Function
REQ-014 FSM states SHALL be IDLE, ENCODE, FLUSH and DONE.
REQ-015 In IDLE, i_start=1 SHALL do the following:
- latch i_encoder_data, K and both polynomials;
- clear the K-1 bit shift register and the symbol counter;
- enter ENCODE.
REQ-016 The first symbol SHALL be valid in the cycle after i_start.
REQ-017 Window w SHALL be {delayed bits, u}, with w[0]=current input bit u and w[j]=input bit j steps earlier.
REQ-018 Outputs SHALL be g0 = XOR-reduce(w & poly0 & Kmask) and g1 = XOR-reduce(w & poly1 & Kmask), where Kmask has bits 0..K-1 set.
REQ-019 A handshake is o_code_valid & i_code_ready in the same cycle.
- On handshake: shift u into the register, increment the counter, present the next symbol in the next cycle.
- One symbol per cycle maximum.
REQ-020 While o_code_valid=1 and i_code_ready=0, o_code and all internal state SHALL hold unchanged.
REQ-021 o_code_valid SHALL be 1 in ENCODE and FLUSH and 0 in IDLE and DONE; o_code SHALL be 2'b00 whenever o_code_valid=0.
REQ-022 ENCODE SHALL emit exactly 128 symbols using u = latched data bit [counter].
REQ-023 After the handshake of symbol 127, the FSM SHALL enter FLUSH (if enabled, see Configuration) or DONE.
REQ-024 FLUSH SHALL emit K-1 symbols with u=0, then enter DONE after the last handshake.
REQ-025 DONE SHALL last one cycle with o_encoder_done=1, then return to IDLE.
REQ-026 o_busy SHALL be 1 in ENCODE, FLUSH and DONE, and 0 in IDLE.
REQ-027 i_start SHALL be ignored when not in IDLE.
REQ-028 Changes to i_constr_len, i_gen_poly*, or i_encoder_data after the load cycle SHALL have no effect until the next load.
REQ-029 The symbol counter SHALL be 8 bits wide and SHALL NOT wrap within a block (max count 136).
REQ-030 i_code_ready asserted while o_code_valid=0 SHALL have no effect.

Reset
REQ-031 rst=1 SHALL asynchronously force the following, regardless of current state:
- FSM to IDLE;
- shift register, counter, latched data and latched configuration to 0;
- o_code=0, o_code_valid=0, o_busy=0, o_encoder_done=0.
REQ-032 An interrupted block SHALL be discarded with no o_encoder_done pulse; the first i_start after rst deasserts SHALL start a fresh block.

Configuration
REQ-033 Macro TAIL_FLUSH_EN SHALL control termination.
- Defined: the FLUSH state is present and K-1 zero tail symbols follow the data, giving 128+K-1 symbols per block with the encoder returned to state 0.
- Undefined: the FLUSH state is not built, ENCODE goes directly to DONE, and each block is exactly 128 symbols.

Verification
REQ-034 Impulse, K=3, poly0=9'h007, poly1=9'h005, data=128'h1, ready=1 -> symbols 11, 10, 11, then 00 until the end; done pulse after 130 symbols (TAIL_FLUSH_EN) or 128 (no macro).
REQ-035 K=9, data=0, ready=1 -> 136 symbols, all 00; o_busy high 137 cycles; o_encoder_done high exactly one cycle after the last handshake.
REQ-036 K=5, random data, ready low for 5 cycles at symbol 10 -> o_code is stable during the stall; the symbol stream matches the reference model with no loss or duplication.
REQ-037 i_start pulsed at symbol 50, with new data and i_constr_len changed -> ignored; the current block completes unchanged.
REQ-038 rst pulsed at symbol 60 -> all outputs 0 in the same cycle; no done pulse; the next i_start encodes a fresh block from a zero state.

Source files
------------

// File: rtl/conv_encoder_if.sv
// Load/config and code-symbol stream bundle for conv_encoder; no logic.
// master drives the load request and ready, slave returns the symbol stream.
interface conv_encoder_if;
  logic [1:0]   i_constr_len;
  logic [8:0]   i_gen_poly0;
  logic [8:0]   i_gen_poly1;
  logic         i_start;
  logic [127:0] i_encoder_data;
  logic         i_code_ready;
  logic [1:0]   o_code;
  logic         o_code_valid;
  logic         o_busy;
  logic         o_encoder_done;

  modport master (
    output i_constr_len, i_gen_poly0, i_gen_poly1, i_start, i_encoder_data, i_code_ready,
    input  o_code, o_code_valid, o_busy, o_encoder_done
  );

  modport slave (
    input  i_constr_len, i_gen_poly0, i_gen_poly1, i_start, i_encoder_data, i_code_ready,
    output o_code, o_code_valid, o_busy, o_encoder_done
  );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder (K=3..9) over a 128-bit block; TAIL_FLUSH_EN adds K-1 zero tail symbols.
// First symbol valid the cycle after i_start, then one symbol per cycle.
// Backpressure: with i_code_ready low the symbol and all state hold.
module conv_encoder (
  input  logic          clk,
  input  logic          rst,
  conv_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
`ifdef TAIL_FLUSH_EN
    FLUSH  = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  state_t       state;
  logic [127:0] data_q;
  logic [1:0]   klen_q;
  logic [8:0]   poly0_q;
  logic [8:0]   poly1_q;
  logic [7:0]   sr_q;
  logic [7:0]   cnt_q;
  logic         valid_q;
  logic         busy_q;
  logic         done_q;

  logic         u_cur;
  logic         hs;
  logic [8:0]   mask;
  logic [8:0]   window;
`ifdef TAIL_FLUSH_EN
  logic [7:0]   tail_last;
`endif

  function automatic logic [8:0] k_mask(input logic [1:0] klen);
    case (klen)
      2'b00:   k_mask = 9'h007;
      2'b01:   k_mask = 9'h01f;
      2'b10:   k_mask = 9'h07f;
      default: k_mask = 9'h1ff;
    endcase
  endfunction

  always_comb begin
    u_cur  = (state == ENCODE) ? data_q[cnt_q[6:0]] : 1'b0;
    hs     = valid_q & bus.i_code_ready;
    mask   = k_mask(klen_q);
    window = {sr_q, u_cur};
`ifdef TAIL_FLUSH_EN
    // Last tail symbol index is 127 + (K-1), K = 3 + 2*klen.
    tail_last = 8'd129 + {5'b00000, klen_q, 1'b0};
`endif
  end

  // Symbol is a pure function of registered state; gated to zero when not valid.
  assign bus.o_code         = valid_q ? {^(window & poly0_q & mask), ^(window & poly1_q & mask)} : 2'b00;
  assign bus.o_code_valid   = valid_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_encoder_done = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      data_q  <= '0;
      klen_q  <= '0;
      poly0_q <= '0;
      poly1_q <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            data_q  <= bus.i_encoder_data;
            klen_q  <= bus.i_constr_len;
            poly0_q <= bus.i_gen_poly0;
            poly1_q <= bus.i_gen_poly1;
            sr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= ENCODE;
          end
        end
        ENCODE: begin
          if (hs) begin
            sr_q  <= {sr_q[6:0], u_cur};
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == 8'd127) begin
`ifdef TAIL_FLUSH_EN
              state   <= FLUSH;
`else
              state   <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
`endif
            end
          end
        end
`ifdef TAIL_FLUSH_EN
        FLUSH: begin
          if (hs) begin
            sr_q  <= {sr_q[6:0], 1'b0};
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == tail_last) begin
              state   <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: impulse, all-zero K=9, stall, ignored restart, mid-block reset.
`timescale 1ns/1ps
module tb_conv_encoder;
  logic clk = 1'b0;
  logic rst;

  conv_encoder_if ifc();

  conv_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

`ifdef TAIL_FLUSH_EN
  localparam bit TAIL = 1'b1;
`else
  localparam bit TAIL = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: symbol idx taps message bit idx-j for each j < K.
  function automatic logic [1:0] ref_sym(input logic [127:0] d, input logic [1:0] kc,
                                         input logic [8:0] p0, input logic [8:0] p1, input int idx);
    int  k;
    int  b;
    logic g0;
    logic g1;
    k  = 3 + 2 * int'(kc);
    g0 = 1'b0;
    g1 = 1'b0;
    for (int j = 0; j < k; j++) begin
      b = idx - j;
      if (b >= 0 && b < 128) begin
        if (d[b]) begin
          g0 = g0 ^ p0[j];
          g1 = g1 ^ p1[j];
        end
      end
    end
    return {g0, g1};
  endfunction

  function automatic int exp_count(input logic [1:0] kc);
    return TAIL ? (130 + 2 * int'(kc)) : 128;
  endfunction

  task automatic start_block(input logic [127:0] d, input logic [1:0] kc,
                             input logic [8:0] p0, input logic [8:0] p1);
    ifc.i_encoder_data = d;
    ifc.i_constr_len   = kc;
    ifc.i_gen_poly0    = p0;
    ifc.i_gen_poly1    = p1;
    ifc.i_start        = 1'b1;
    @(posedge clk); #1;
    ifc.i_start = 1'b0;
    check("first_valid", ifc.o_code_valid, 1);
    check("busy_on", ifc.o_busy, 1);
  endtask

  task automatic drain(input string tag, input logic [127:0] d, input logic [1:0] kc,
                       input logic [8:0] p0, input logic [8:0] p1, input int n0,
                       input int stall_at, input int stall_len, input int poke_at,
                       input int abort_at, output int busy_cyc);
    int   n;
    int   cyc;
    int   stall_left;
    int   exp_n;
    bit   done_seen;
    bit   stalled;
    bit   poked;
    logic [1:0] held;
    exp_n      = exp_count(kc);
    n          = n0;
    cyc        = 0;
    busy_cyc   = 0;
    stall_left = 0;
    done_seen  = 1'b0;
    stalled    = 1'b0;
    poked      = 1'b0;
    held       = 2'b00;
    while (!done_seen && cyc < 1000) begin
      cyc++;
      ifc.i_start = 1'b0;
      if (ifc.o_busy) busy_cyc++;
      if (ifc.o_encoder_done) begin
        done_seen = 1'b1;
        check({tag, "_count"}, n, exp_n);
        check({tag, "_done_code"}, {ifc.o_code_valid, ifc.o_code}, 0);
      end else begin
        if (n == abort_at) begin
          rst = 1'b1;
          #1;
          check({tag, "_rst_outs"},
                {ifc.o_code, ifc.o_code_valid, ifc.o_busy, ifc.o_encoder_done}, 0);
          return;
        end
        if (n == poke_at && !poked) begin
          poked              = 1'b1;
          ifc.i_start        = 1'b1;
          ifc.i_encoder_data = ~d;
          ifc.i_constr_len   = kc + 2'd1;
          ifc.i_gen_poly0    = ~p0;
          ifc.i_gen_poly1    = ~p1;
        end
        if (n == stall_at && !stalled) begin
          stalled    = 1'b1;
          stall_left = stall_len;
          held       = ifc.o_code;
        end
        if (stall_left > 0) begin
          stall_left--;
          ifc.i_code_ready = 1'b0;
          check({tag, "_stall_hold"}, ifc.o_code, held);
          check({tag, "_stall_sym"}, {ifc.o_code_valid, ifc.o_code}, {1'b1, ref_sym(d, kc, p0, p1, n)});
        end else begin
          ifc.i_code_ready = 1'b1;
          check({tag, "_sym"}, {ifc.o_code_valid, ifc.o_code}, {1'b1, ref_sym(d, kc, p0, p1, n)});
          n++;
        end
      end
      @(posedge clk); #1;
    end
    check({tag, "_done_seen"}, done_seen, 1);
    check({tag, "_after_done"}, {ifc.o_encoder_done, ifc.o_busy, ifc.o_code_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cyc;
    logic [127:0] dat5;
    logic [127:0] dat7;
    dat5 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    dat7 = 128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0;

    rst                = 1'b1;
    ifc.i_start        = 1'b0;
    ifc.i_code_ready   = 1'b0;
    ifc.i_encoder_data = '0;
    ifc.i_constr_len   = 2'b00;
    ifc.i_gen_poly0    = '0;
    ifc.i_gen_poly1    = '0;
    #12;
    check("rst_code", ifc.o_code, 0);
    check("rst_valid", ifc.o_code_valid, 0);
    check("rst_busy", ifc.o_busy, 0);
    check("rst_done", ifc.o_encoder_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Ready while idle must not start anything.
    ifc.i_code_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready", {ifc.o_code_valid, ifc.o_busy, ifc.o_code}, 0);

    // Impulse, K=3, (7,5): 11, 10, 11 then zeros.
    start_block(128'h1, 2'b00, 9'h007, 9'h005);
    check("imp_s0", ifc.o_code, 2'b11);
    @(posedge clk); #1;
    check("imp_s1", ifc.o_code, 2'b10);
    @(posedge clk); #1;
    check("imp_s2", ifc.o_code, 2'b11);
    @(posedge clk); #1;
    drain("imp", 128'h1, 2'b00, 9'h007, 9'h005, 3, -1, 0, -1, -1, busy_cyc);

    // All-zero block at K=9: busy spans every symbol plus the DONE cycle.
    start_block('0, 2'b11, 9'h171, 9'h1eb);
    drain("k9", '0, 2'b11, 9'h171, 9'h1eb, 0, -1, 0, -1, -1, busy_cyc);
    check("k9_busy_cycles", busy_cyc, exp_count(2'b11) + 1);

    // K=5 with a 5-cycle stall at symbol 10.
    start_block(dat5, 2'b01, 9'h013, 9'h01d);
    drain("k5_stall", dat5, 2'b01, 9'h013, 9'h01d, 0, 10, 5, -1, -1, busy_cyc);
    check("k5_busy_cycles", busy_cyc, exp_count(2'b01) + 6);

    // K=3 with taps above K set; restart attempt at symbol 50 must be ignored.
    start_block(dat7, 2'b00, 9'h1a7, 9'h0f5);
    drain("poke", dat7, 2'b00, 9'h1a7, 9'h0f5, 0, -1, 0, 50, -1, busy_cyc);

    // Reset at symbol 60 of a K=7 block: no done pulse, next block starts clean.
    start_block(dat7, 2'b10, 9'h079, 9'h05b);
    drain("abort", dat7, 2'b10, 9'h079, 9'h05b, 0, -1, 0, -1, 60, busy_cyc);
    @(posedge clk); #3;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_quiet", {ifc.o_encoder_done, ifc.o_busy, ifc.o_code_valid}, 0);
    end
    start_block(dat7, 2'b10, 9'h079, 9'h05b);
    drain("fresh", dat7, 2'b10, 9'h079, 9'h05b, 0, -1, 0, -1, -1, busy_cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
